// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with timed memory handshake
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (accept bne, funct3 001, in BRANCH).
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] Flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] AluControl,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LIMIT = CW'(MEM_TIMEOUT);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          alu_f3_ok, br_f3_ok, branch_taken, waiting, timeout;
    logic [2:0]    exec_alu;
    logic          unused_flag_neg;

    assign unused_flag_neg = Flag[1];
    assign state_o         = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
`ifdef MULTICYCLE_CTRL_BNE_EN
        br_f3_ok     = (funct3 == 3'b000) || (funct3 == 3'b001);
        branch_taken = ((funct3 == 3'b000) && Flag[0]) || ((funct3 == 3'b001) && !Flag[0]);
`else
        br_f3_ok     = (funct3 == 3'b000);
        branch_taken = (funct3 == 3'b000) && Flag[0];
`endif
        case (funct3)
            3'b000:  exec_alu = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  exec_alu = ALU_SLT;
            3'b110:  exec_alu = ALU_OR;
            3'b111:  exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
        endcase
    end

    // Only the three requesting states count; a zero limit disables the timeout.
    assign waiting = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt_q == TMO_LIMIT);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        AluControl    = ALU_ADD;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (timeout) begin
                    bus_error = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = FETCH;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:   if (alu_f3_ok) state_d = EXECR; else illegal_instr = 1'b1;
                    OP_I:   if (alu_f3_ok) state_d = EXECI; else illegal_instr = 1'b1;
                    OP_BR:  if (br_f3_ok) state_d = BRANCH; else illegal_instr = 1'b1;
                    OP_JAL: state_d = JAL;
                    default: illegal_instr = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = FETCH;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                    else           wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = FETCH;
                end else begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) state_d = FETCH;
                    else           wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            EXECR, EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = (state_q == EXECI) ? 2'b01 : 2'b00;
                AluControl = exec_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                AluControl = ALU_SUB;
                pc_write   = branch_taken;
                state_d    = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase

        // Reset silences every strobe combinationally, so a live access drops at once.
        if (reset) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            result_src    = 2'b00;
            AluControl    = ALU_ADD;
            illegal_instr = 1'b0;
            bus_error     = 1'b0;
            wait_cnt_d    = '0;
            state_d       = FETCH;
        end
    end
endmodule
